// File: rtl/io_controller_pkg.sv
// rtl/io_controller_pkg.sv - shared encodings and helpers for the I/O request controller
package io_controller_pkg;

    localparam int LEN_WORD = 32;

    localparam logic [1:0] IO_SIZE_BYTE = 2'd0;
    localparam logic [1:0] IO_SIZE_HALF = 2'd1;
    localparam logic [1:0] IO_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } io_state_t;

    // Size code 3 is not a legal request size; it is served as a full word.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            IO_SIZE_BYTE: return 3'd1;
            IO_SIZE_HALF: return 3'd2;
            default:      return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/io_controller_if.sv
// rtl/io_controller_if.sv - core request channel plus UART byte streams
interface io_controller_if;
    import io_controller_pkg::*;

    logic                io_flag;
    logic                io_write_flag;
    logic [1:0]          io_size;
    logic [LEN_WORD-1:0] io_i_data;
    logic [LEN_WORD-1:0] io_o_data;
    logic                io_accessed;

    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ready;

    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;

    modport slave (
        input  io_flag, io_write_flag, io_size, io_i_data, rx_data, rx_valid, tx_ready,
        output io_o_data, io_accessed, rx_ready, tx_data, tx_valid
    );

    modport master (
        output io_flag, io_write_flag, io_size, io_i_data, rx_data, rx_valid, tx_ready,
        input  io_o_data, io_accessed, rx_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - synchronous byte FIFO with show-ahead read port
module io_fifo #(
    parameter int DEPTH_LOG = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);

    logic [7:0]           mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic [DEPTH_LOG:0]   count;
    logic                 do_push;
    logic                 do_pop;

    // Flags come from the registered count, so a push into a full FIFO is
    // refused even when a pop frees a slot in the same cycle, and a byte
    // pushed into an empty FIFO is not visible for popping until next cycle.
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/io_controller.sv
// rtl/io_controller.sv - serves core I/O requests over UART TX/RX byte streams
module io_controller
    import io_controller_pkg::*;
#(
    parameter int RX_DEPTH_LOG = 4
) (
    input  logic            clk,
    input  logic            rstn,
    io_controller_if.slave  bus
);

    io_state_t           state;
    io_state_t           state_next;
    logic [LEN_WORD-1:0] data_q;
    logic [LEN_WORD-1:0] asm_q;
    logic [LEN_WORD-1:0] asm_next;
    logic [LEN_WORD-1:0] io_o_data_q;
    logic [2:0]          nbytes_q;
    logic [1:0]          idx_q;
    logic                last_byte;
    logic                fifo_pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic [7:0]          fifo_dout;
    logic                tx_valid;
    logic [7:0]          tx_data;
    logic                io_accessed;

    io_fifo #(
        .DEPTH_LOG (RX_DEPTH_LOG)
    ) u_rx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.rx_valid),
        .din   (bus.rx_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.rx_ready    = !fifo_full;
    assign bus.tx_valid    = tx_valid;
    assign bus.tx_data     = tx_data;
    assign bus.io_accessed = io_accessed;
    assign bus.io_o_data   = io_o_data_q;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state and stream/handshake outputs; everything is decoded from
    // state so an asynchronous reset drops tx_valid and io_accessed at once.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        io_accessed = 1'b0;
        asm_next   = asm_q;
        last_byte  = ({1'b0, idx_q} == (nbytes_q - 3'd1));
        case (state)
            ST_IDLE: begin
                if (bus.io_flag) state_next = bus.io_write_flag ? ST_SEND : ST_RECV;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = data_q[{idx_q, 3'b000} +: 8];
                if (bus.tx_ready && last_byte) state_next = ST_DONE;
            end
            ST_RECV: begin
                fifo_pop = 1'b1;
                if (!fifo_empty) begin
                    asm_next[{idx_q, 3'b000} +: 8] = fifo_dout;
                    if (last_byte) state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                io_accessed = 1'b1;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch, byte index and read assembly; io_o_data is loaded on the
    // final pop so the assembled value is already presented during DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q      <= '0;
            asm_q       <= '0;
            io_o_data_q <= '0;
            nbytes_q    <= 3'd1;
            idx_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.io_flag) begin
                        data_q   <= bus.io_i_data;
                        nbytes_q <= size_to_nbytes(bus.io_size);
                        idx_q    <= '0;
                        asm_q    <= '0;
                    end
                end
                ST_SEND: begin
                    if (bus.tx_ready) idx_q <= idx_q + 1'b1;
                end
                ST_RECV: begin
                    if (!fifo_empty) begin
                        asm_q <= asm_next;
                        idx_q <= idx_q + 1'b1;
                        if (last_byte) io_o_data_q <= asm_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_controller.sv
// tb/tb_io_controller.sv - directed and randomized checks against a queue model
module tb_io_controller;
    import io_controller_pkg::*;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    logic [7:0]  rxq [$];
    logic [7:0]  pend [$];
    logic [31:0] last_rd;

    io_controller_if bus ();

    io_controller dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] size);
        if (size == 2'd0) return 1;
        if (size == 2'd1) return 2;
        return 4;
    endfunction

    task automatic push_idle(input logic [7:0] b);
        check("rx_ready_level", {31'd0, bus.rx_ready}, {31'd0, rxq.size() < 16});
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        if (rxq.size() < 16) rxq.push_back(b);
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] size, input logic [31:0] data, input int stall);
        int nb;
        logic [31:0] d;
        nb = nbytes_of(size);
        d  = data;
        bus.io_flag       = 1'b1;
        bus.io_write_flag = 1'b1;
        bus.io_size       = size;
        bus.io_i_data     = data;
        bus.tx_ready      = 1'b1;
        step();
        for (int k = 0; k < nb; k++) begin
            for (int s = 0; s < stall; s++) begin
                bus.tx_ready = 1'b0;
                check("wr_stall_valid", {31'd0, bus.tx_valid}, 32'd1);
                check("wr_stall_data", {24'd0, bus.tx_data}, {24'd0, d[8*k +: 8]});
                check("wr_no_early_ack", {31'd0, bus.io_accessed}, 32'd0);
                step();
            end
            bus.tx_ready = 1'b1;
            check("wr_valid", {31'd0, bus.tx_valid}, 32'd1);
            check("wr_data", {24'd0, bus.tx_data}, {24'd0, d[8*k +: 8]});
            step();
        end
        check("wr_ack", {31'd0, bus.io_accessed}, 32'd1);
        check("wr_valid_drop", {31'd0, bus.tx_valid}, 32'd0);
        check("wr_odata_kept", bus.io_o_data, last_rd);
        bus.io_flag = 1'b0;
        step();
        check("wr_ack_one_cycle", {31'd0, bus.io_accessed}, 32'd0);
    endtask

    task automatic do_read(input logic [1:0] size, input int quiet, input int maxgap, input bit timed);
        int nb;
        int cyc;
        bit seen;
        logic [31:0] exp;
        nb   = nbytes_of(size);
        cyc  = 0;
        seen = 1'b0;
        bus.io_flag       = 1'b1;
        bus.io_write_flag = 1'b0;
        bus.io_size       = size;
        bus.io_i_data     = $urandom;
        while (cyc < 300 && !seen) begin
            bus.rx_valid = 1'b0;
            if (cyc >= quiet && pend.size() > 0 && rxq.size() < 16 &&
                $urandom_range(0, maxgap) == 0) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = pend.pop_front();
                rxq.push_back(bus.rx_data);
            end
            step();
            cyc++;
            if (cyc <= quiet) check("rd_stall_no_ack", {31'd0, bus.io_accessed}, 32'd0);
            if (bus.io_accessed) seen = 1'b1;
        end
        bus.rx_valid = 1'b0;
        check("rd_ack_seen", {31'd0, seen}, 32'd1);
        exp = '0;
        for (int k = 0; k < nb; k++) begin
            if (rxq.size() > 0) exp[8*k +: 8] = rxq.pop_front();
        end
        check("rd_data", bus.io_o_data, exp);
        last_rd = exp;
        if (timed) check("rd_latency", cyc, nb + 1);
        bus.io_flag = 1'b0;
        step();
        check("rd_ack_one_cycle", {31'd0, bus.io_accessed}, 32'd0);
        check("rd_data_hold", bus.io_o_data, last_rd);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        last_rd = '0;
        rstn              = 1'b0;
        bus.io_flag       = 1'b0;
        bus.io_write_flag = 1'b0;
        bus.io_size       = 2'd0;
        bus.io_i_data     = '0;
        bus.rx_data       = 8'h00;
        bus.rx_valid      = 1'b0;
        bus.tx_ready      = 1'b1;

        step();
        check("rst_odata", bus.io_o_data, 32'd0);
        check("rst_ack", {31'd0, bus.io_accessed}, 32'd0);
        check("rst_txv", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_txd", {24'd0, bus.tx_data}, 32'd0);
        rstn = 1'b1;
        step();
        check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);

        do_write(2'd0, 32'h0000_00A5, 0);
        do_write(2'd2, 32'h1122_3344, 3);

        push_idle(8'hEF);
        push_idle(8'hBE);
        push_idle(8'hAD);
        push_idle(8'hDE);
        do_read(2'd2, 0, 0, 1'b1);
        check("word_read_value", last_rd, 32'hDEAD_BEEF);

        pend.push_back(8'h34);
        pend.push_back(8'h12);
        do_read(2'd1, 5, 3, 1'b0);
        check("half_read_value", last_rd, 32'h0000_1234);

        for (int i = 0; i < 17; i++) push_idle(8'h10 + 8'(i));
        check("fifo_full_ready", {31'd0, bus.rx_ready}, 32'd0);
        check("fifo_model_count", rxq.size(), 16);
        for (int w = 0; w < 4; w++) do_read(2'd2, 0, 0, 1'b1);
        check("wrap_last_word", last_rd, 32'h1F1E_1D1C);

        push_idle(8'hA1);
        push_idle(8'hA2);
        push_idle(8'hA3);
        push_idle(8'hA4);
        bus.io_flag       = 1'b1;
        bus.io_write_flag = 1'b0;
        bus.io_size       = 2'd2;
        step();
        step();
        step();
        rstn = 1'b0;
        #1;
        check("midrst_ack", {31'd0, bus.io_accessed}, 32'd0);
        check("midrst_odata", bus.io_o_data, 32'd0);
        check("midrst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        rxq.delete();
        last_rd     = '0;
        bus.io_flag = 1'b0;
        step();
        rstn = 1'b1;
        step();
        pend.push_back(8'h7F);
        do_read(2'd0, 0, 0, 1'b0);
        check("post_rst_read", last_rd, 32'h0000_007F);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] sz;
            int nb;
            sz = 2'($urandom_range(0, 3));
            nb = nbytes_of(sz);
            if ($urandom_range(0, 1) == 1) begin
                do_write(sz, $urandom, $urandom_range(0, 2));
            end else begin
                int pre;
                pre = $urandom_range(0, 4);
                for (int i = 0; i < pre; i++) begin
                    if (rxq.size() < 16) push_idle(8'($urandom));
                end
                while (rxq.size() + pend.size() < nb) pend.push_back(8'($urandom));
                do_read(sz, 0, 2, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
